// File: rtl/coeff_pkg.sv
// Shared widths, FSM encoding and payload types for the coefficient bank controller.
package coeff_pkg;

    localparam int unsigned ADDR_W  = 6;
    localparam int unsigned WADDR_W = 9;
    localparam int unsigned DATA_W  = 36;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Tag travelling alongside each read address until its data emerges from the banks
    typedef struct packed {
        logic valid;
        logic first;
        logic last;
    } coeff_tag_t;

    typedef struct packed {
        logic [WADDR_W-1:0] addr;
        logic [DATA_W-1:0]  data;
    } wr_cmd_t;

endpackage

// File: rtl/coeff_valid_pipe.sv
// Delay line aligning the valid/first/last tags with the coefficient memory read latency.
module coeff_valid_pipe
    import coeff_pkg::*;
#(
    parameter int unsigned MEM_LATENCY = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       clear,
    input  coeff_tag_t tag_in,
    output coeff_tag_t tag_out
);

    localparam int unsigned PIPE_W = MEM_LATENCY * $bits(coeff_tag_t);

    coeff_tag_t [MEM_LATENCY-1:0] stage_q;

    // Newest tag enters at index 0; the oldest falls off the top
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stage_q <= '0;
        end else if (clear) begin
            stage_q <= '0;
        end else begin
            stage_q <= PIPE_W'({stage_q, tag_in});
        end
    end

    assign tag_out = stage_q[MEM_LATENCY-1];

endmodule

// File: rtl/coeff_bank_ctrl.sv
// Coefficient bank controller: sweeps a common read address over 8 banks and
// arbitrates serial-interface writes into the banks while no sweep is running.
module coeff_bank_ctrl
    import coeff_pkg::*;
#(
    parameter int unsigned MEM_LATENCY = 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [ADDR_W-1:0]  last_addr,
    input  logic               abort,
    input  logic               wr_req,
    input  logic [WADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0]  wr_data,
    output logic               wr_ack,
    output logic               mem_we,
    output logic [WADDR_W-1:0] mem_addressW,
    output logic [DATA_W-1:0]  mem_datain,
    output logic [ADDR_W-1:0]  mem_addressR,
    output logic               coeff_valid,
    output logic               coeff_first,
    output logic               coeff_last,
    output logic               busy,
    output logic               done
);

    state_t            state_q;
    state_t            state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_d;
    logic [ADDR_W-1:0] last_q;
    logic [ADDR_W-1:0] last_d;
    logic              at_last_c;
    logic              clear_c;
    coeff_tag_t        tag_c;
    coeff_tag_t        tag_out;
    wr_cmd_t           wr_q;
    logic              we_q;
    logic              busy_q;

    assign at_last_c = (addr_q == last_q);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (abort) state_d = IDLE;
                     else if (at_last_c) state_d = DRAIN;
            DRAIN:   if (abort || tag_out.last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Address sequencing, tag generation and the write handshake per state
    always_comb begin
        addr_d  = addr_q;
        last_d  = last_q;
        tag_c   = '0;
        clear_c = 1'b0;
        wr_ack  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    addr_d = '0;
                    last_d = last_addr;
                end
                wr_ack = reset && wr_req && !start;
            end
            RUN: begin
                tag_c.valid = 1'b1;
                tag_c.first = (addr_q == '0);
                tag_c.last  = at_last_c;
                clear_c     = abort;
                if (!abort && !at_last_c) addr_d = addr_q + ADDR_W'(1);
            end
            DRAIN: begin
                clear_c = abort;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            addr_q <= '0;
            last_q <= '0;
            busy_q <= 1'b0;
            we_q   <= 1'b0;
            wr_q   <= '0;
        end else begin
            addr_q <= addr_d;
            last_q <= last_d;
            busy_q <= (state_d != IDLE);
            we_q   <= wr_ack;
            if (wr_ack) wr_q <= '{addr: wr_addr, data: wr_data};
        end
    end

    coeff_valid_pipe #(
        .MEM_LATENCY(MEM_LATENCY)
    ) u_valid_pipe (
        .clock   (clock),
        .reset   (reset),
        .clear   (clear_c),
        .tag_in  (tag_c),
        .tag_out (tag_out)
    );

    assign mem_addressR = addr_q;
    assign mem_we       = we_q;
    assign mem_addressW = wr_q.addr;
    assign mem_datain   = wr_q.data;
    assign busy         = busy_q;
    assign coeff_valid  = tag_out.valid;
    assign coeff_first  = tag_out.first;
    assign coeff_last   = tag_out.last;
    // The last tag only ever emerges during DRAIN, so it doubles as the done pulse
    assign done         = tag_out.last;

endmodule
